// File: rtl/mux_nto1_rr_if.sv
// mux_nto1_rr_if -- channel bundle for the N-to-1 round-robin/fixed mux.
//   Producer side: mode, sel, in_data, in_valid (in), in_ready (out)
//   Consumer side: out_data, out_ch, out_valid (out), out_ready (in)
//   slave  : view taken by the mux itself
//   master : view taken by whoever drives the channels and sinks the output
interface mux_nto1_rr_if #(
  parameter int WIDTH = 3,
  parameter int NCH   = 8
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                   mode;
  logic [SELW-1:0]        sel;
  logic [NCH*WIDTH-1:0]   in_data;
  logic [NCH-1:0]         in_valid;
  logic [NCH-1:0]         in_ready;
  logic [WIDTH-1:0]       out_data;
  logic [SELW-1:0]        out_ch;
  logic                   out_valid;
  logic                   out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid
  );
endinterface

// File: rtl/mux_nto1_rr.sv
// mux_nto1_rr -- registered N-to-1 channel multiplexer with per-channel
// valid/ready, selectable fixed-select or round-robin arbitration.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_nto1_rr_if.slave (mode, sel, in_data, in_valid, in_ready,
//           out_data, out_ch, out_valid, out_ready)
// One output register stage; a new word may be accepted in the same cycle
// the held word drains, so throughput is one word per cycle.
module mux_nto1_rr #(
  parameter int WIDTH = 3,
  parameter int NCH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mux_nto1_rr_if.slave   bus
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic [SELW-1:0]  r_ptr;

  logic             w_load;
  logic             w_gnt_vld;
  logic [SELW-1:0]  w_gnt_idx;
  logic [WIDTH-1:0] w_gnt_data;
  logic [NCH-1:0]   w_in_ready;
  logic             w_xfer;

  assign w_load = !r_out_valid || bus.out_ready;

  // Grant selection. Round-robin is done as two linear passes: first the
  // channels at or above the pointer, then the ones below it, which is the
  // same as a wrapped scan starting at ptr.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (!bus.mode) begin
      // An out-of-range sel matches no channel, so nothing is ever granted.
      for (int i = 0; i < NCH; i++) begin
        if (int'(bus.sel) == i && bus.in_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SELW'(i);
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (!w_gnt_vld && bus.in_valid[i] && i >= int'(r_ptr)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SELW'(i);
        end
      end
      for (int i = 0; i < NCH; i++) begin
        if (!w_gnt_vld && bus.in_valid[i] && i < int'(r_ptr)) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = SELW'(i);
        end
      end
    end
  end

  always_comb begin
    w_gnt_data = '0;
    w_in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_gnt_idx == SELW'(i)) begin
        w_gnt_data = bus.in_data[i*WIDTH +: WIDTH];
      end
      // rst_n gates ready so nothing handshakes while reset is held.
      w_in_ready[i] = rst_n && w_load && w_gnt_vld && (w_gnt_idx == SELW'(i));
    end
  end

  // A granted channel is always valid, so load plus grant is a transfer.
  assign w_xfer = w_load && w_gnt_vld;

  // Output register stage and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_ptr       <= '0;
    end else begin
      if (w_load) begin
        r_out_valid <= w_xfer;
        if (w_xfer) begin
          r_out_data <= w_gnt_data;
          r_out_ch   <= w_gnt_idx;
        end
      end
      if (w_xfer && bus.mode) begin
        r_ptr <= (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);
      end
    end
  end

  assign bus.out_data  = r_out_data;
  assign bus.out_ch    = r_out_ch;
  assign bus.out_valid = r_out_valid;
  assign bus.in_ready  = w_in_ready;

endmodule

// File: doc/mux_nto1_rr.md
Name: mux_nto1_rr

Overview:
Parametrised registered N-to-1 channel multiplexer with a per-channel valid/ready handshake and a registered output stage.
Two modes:
- Fixed mode: an external select code picks the channel.
- Round-robin mode: the block arbitrates fairly among valid channels.
It sits between multiple producer channels and one downstream consumer, and replaces the combinational 8:1 3-bit selector where fairness, back-pressure or other sizes are needed.

Parameters:
WIDTH, 3, data bits per channel
NCH, 8, number of input channels (2..64, need not be a power of 2); SELW = max(1, clog2(NCH)) is derived internally

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
mode  input  1  0 = fixed select, 1 = round-robin
sel  input  SELW  channel index used in fixed mode (channel 0 = code 0)
in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
in_valid  input  NCH  per-channel valid
in_ready  output  NCH  per-channel ready, combinational, at most one bit high
out_data  output  WIDTH  registered selected data
out_ch  output  SELW  registered index of the channel that produced out_data
out_valid  output  1  registered output valid
out_ready  input  1  downstream ready

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_data=0, out_ch=0, RR pointer ptr=0. While in reset, in_ready=0 (follows from out_valid=0 only after reset release; during reset force all in_ready to 0). Any held word is discarded.
- Load condition: load = !out_valid || out_ready. The output stage is one register deep, and throughput is 1 word per cycle when unstalled.
- Grant, combinational, evaluated every cycle:
  - Fixed mode: grant to channel sel only if sel < NCH and in_valid[sel]=1. If sel >= NCH, there is no grant and nothing is ever accepted.
  - RR mode: scan channels ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrapping modulo NCH). Grant the first channel with in_valid=1. If no channel is valid, there is no grant.
- Handshake: in_ready[g] = load && grant valid && g == granted index; all other bits are 0. A transfer occurs on in_valid[g] && in_ready[g].
- On transfer at a clock edge: out_data <= channel g data, out_ch <= g, out_valid <= 1. Latency is 1 cycle from input acceptance to out_valid.
- On load with no transfer: out_valid <= 0. out_data and out_ch hold their previous values (don't-care while invalid).
- Stall (out_valid=1, out_ready=0): out_data, out_ch and out_valid hold stable, and all in_ready=0. Simultaneous drain and refill in the same cycle is allowed, with no bubble.
- RR pointer:
  - Updated only on a transfer while mode=1: ptr <= (g == NCH-1) ? 0 : g+1.
  - Fixed-mode transfers leave ptr unchanged.
  - A mode change takes effect at the next grant evaluation, with no flush; the held output word is unaffected.
- Fairness: in RR mode, with all channels continuously valid and out_ready=1, each channel is granted exactly once per NCH consecutive transfers.
- Inputs sampled only via the handshake; in_data of non-granted channels is ignored. in_valid may drop without a transfer (no stickiness required at this block).
- No X propagation: out_data is driven from a register in all states.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_data=0, out_ch=0, in_ready=0 immediately (async); after release, first RR grant goes to channel 0.
- Fixed mode, NCH=8, WIDTH=3: mode=0, sel=3, in_valid=8'hFF, channel i data = i, out_ready=1 -> in_ready=8'b0000_1000; next cycle out_data=3, out_ch=3, out_valid=1.
- Out-of-range select, NCH=6: mode=0, sel=7, all valid -> in_ready=0 forever; out_valid stays 0.
- RR full load: mode=1, in_valid=8'hFF, out_ready=1 for 16 cycles -> out_ch sequence 0,1,…,7,0,…,7 on consecutive cycles.
- RR sparse with wrap: ptr=6, in_valid={ch1, ch5} -> grants 1, 5, 1, 5; set ptr to 6 via a transfer from ch5, then grant ch1 (wrap).
- Back-pressure: out_valid=1, out_ready=0 for 3 cycles -> out_data and out_ch stable, in_ready=0; then out_ready=1 -> the same cycle accepts the next channel and out_valid stays 1 with no bubble.
